// File: rtl/event_packer.sv
// Slow-path event packetizer: snapshots event results on acceptance and streams
// a fixed-length packet with an XOR checksum trailer into the slow FIFO.
module event_packer #(
  parameter int          NCH        = 4,
  parameter int          DATA_WIDTH = 16,
  parameter int          SF_WIDTH   = 32,
  parameter logic [31:0] PID        = 32'h4142504d,
  parameter logic [31:0] CAL_PID    = 32'h4143414c
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      evt_rdy,
  input  logic                      cal_flag,
  input  logic                      rst_evt_no,
  input  logic [DATA_WIDTH-1:0]     status,
  input  logic [DATA_WIDTH-1:0]     x,
  input  logic [DATA_WIDTH-1:0]     y,
  input  logic [DATA_WIDTH-1:0]     s,
  input  logic [NCH*SF_WIDTH-1:0]   power,
  input  logic [NCH*DATA_WIDTH-1:0] max,
  input  logic                      fifo_prog_full,
  output logic                      fifo_wr,
  output logic [31:0]               fifo_din,
  output logic                      busy,
  output logic [15:0]               evt_cnt,
  output logic [15:0]               drop_cnt
);

  localparam int          L   = 5 + NCH + NCH / 2;
  localparam int          IW  = $clog2(L + 1);
  localparam logic [15:0] LEN = 16'(L);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state, state_nxt;
  logic                      accept, drop;
  logic [IW-1:0]             idx;
  logic [31:0]               csum, word;
  logic [DATA_WIDTH-1:0]     snap_status, snap_x, snap_y, snap_s;
  logic [NCH*SF_WIDTH-1:0]   snap_power;
  logic [NCH*DATA_WIDTH-1:0] snap_max;
  logic [15:0]               snap_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // SEND also spans the cycle that retires fifo_wr, so an event coincident
  // with the last word is still seen as busy and dropped.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (evt_rdy) begin
          if (fifo_prog_full) begin
            drop = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = SEND;
          end
        end
      end
      SEND: begin
        drop = evt_rdy;
        if (idx == IW'(L)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    word = '0;
    if (idx == IW'(1)) word = {16'(snap_status), snap_cnt};
    if (idx == IW'(2)) word = {16'(snap_x), 16'(snap_y)};
    if (idx == IW'(3)) word = {16'(snap_s), LEN};
    for (int unsigned c = 0; c < NCH; c++) begin
      if (idx == IW'(4 + c)) word = 32'(snap_power[c*SF_WIDTH +: SF_WIDTH]);
    end
    for (int unsigned k = 0; k < NCH / 2; k++) begin
      if (idx == IW'(4 + NCH + k))
        word = {16'(snap_max[(2*k)*DATA_WIDTH +: DATA_WIDTH]),
                16'(snap_max[(2*k+1)*DATA_WIDTH +: DATA_WIDTH])};
    end
    if (idx == IW'(L - 1)) word = csum;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      snap_status <= status;
      snap_x      <= x;
      snap_y      <= y;
      snap_s      <= s;
      snap_power  <= power;
      snap_max    <= max;
      if (rst_evt_no)    snap_cnt <= '0;
      else if (cal_flag) snap_cnt <= evt_cnt;
      else               snap_cnt <= evt_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
      busy     <= 1'b0;
      evt_cnt  <= '0;
      drop_cnt <= '0;
      idx      <= '0;
      csum     <= '0;
    end else begin
      if (rst_evt_no) begin
        evt_cnt  <= '0;
        drop_cnt <= '0;
      end else begin
        if (accept && !cal_flag) evt_cnt <= evt_cnt + 16'd1;
        if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
      end
      // Header goes out straight from the inputs; the rest from the snapshot.
      if (accept) begin
        fifo_wr  <= 1'b1;
        busy     <= 1'b1;
        fifo_din <= cal_flag ? CAL_PID : PID;
        csum     <= cal_flag ? CAL_PID : PID;
        idx      <= IW'(1);
      end else if (state == SEND) begin
        if (idx == IW'(L)) begin
          fifo_wr <= 1'b0;
          busy    <= 1'b0;
        end else begin
          fifo_din <= word;
          csum     <= csum ^ word;
          idx      <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_event_packer.sv
// Directed bench for event_packer: NCH=4 instance for packet content, timing,
// drop and reset behaviour, plus an NCH=8 instance for the longer packet.
module tb_event_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         evt_rdy = 1'b0, cal_flag = 1'b0, rst_evt_no = 1'b0;
  logic [15:0]  status = 16'h0001, x = 16'h0102, y = 16'h0304, s = 16'h0506;
  logic [127:0] power = {32'h44, 32'h33, 32'h22, 32'h11};
  logic [63:0]  max = {16'hD, 16'hC, 16'hB, 16'hA};
  logic         fifo_prog_full = 1'b0;
  logic         fifo_wr, busy;
  logic [31:0]  fifo_din;
  logic [15:0]  evt_cnt, drop_cnt;

  logic         evt8 = 1'b0;
  logic [255:0] power8 = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
  logic [127:0] max8 = {16'h8, 16'h7, 16'h6, 16'h5, 16'h4, 16'h3, 16'h2, 16'h1};
  logic         fifo_wr8, busy8;
  logic [31:0]  fifo_din8;
  logic [15:0]  evt_cnt8, drop_cnt8;

  int          tests = 0, fails = 0, busy_err = 0;
  logic [31:0] got[0:31];

  always #5 clk = ~clk;

  event_packer #(.NCH(4)) dut (
    .clk(clk), .rst(rst), .evt_rdy(evt_rdy), .cal_flag(cal_flag), .rst_evt_no(rst_evt_no),
    .status(status), .x(x), .y(y), .s(s), .power(power), .max(max),
    .fifo_prog_full(fifo_prog_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din),
    .busy(busy), .evt_cnt(evt_cnt), .drop_cnt(drop_cnt)
  );

  event_packer #(.NCH(8)) dut8 (
    .clk(clk), .rst(rst), .evt_rdy(evt8), .cal_flag(1'b0), .rst_evt_no(1'b0),
    .status(status), .x(x), .y(y), .s(s), .power(power8), .max(max8),
    .fifo_prog_full(1'b0), .fifo_wr(fifo_wr8), .fifo_din(fifo_din8),
    .busy(busy8), .evt_cnt(evt_cnt8), .drop_cnt(drop_cnt8)
  );

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic cal);
    evt_rdy = 1'b1; cal_flag = cal;
    @(negedge clk);
    evt_rdy = 1'b0; cal_flag = 1'b0;
  endtask

  // Collects one contiguous burst from the NCH=4 instance, bounded to 40 cycles.
  task automatic capture(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (fifo_wr) begin
        if (n < 32) got[n] = fifo_din;
        n++;
        if (busy !== 1'b1) busy_err++;
      end else begin
        if (busy !== 1'b0) busy_err++;
        if (n > 0) break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({fifo_wr, busy, fifo_din, evt_cnt, drop_cnt} !== '0) begin
      fails++;
      $display("FAIL reset: wr=%b busy=%b din=%h evt=%h drop=%h, want all zero",
               fifo_wr, busy, fifo_din, evt_cnt, drop_cnt);
    end
  endtask

  task automatic test_single();
    logic [31:0] exp[11];
    int n;
    exp = '{32'h4142504d, 32'h00010001, 32'h01020304, 32'h0506000B, 32'h11, 32'h22,
            32'h33, 32'h44, 32'h000A000B, 32'h000C000D, 32'h0};
    for (int i = 0; i < 10; i++) exp[10] ^= exp[i];
    busy_err = 0;
    pulse(1'b0);
    capture(n);
    tests++;
    if (n != 11) begin fails++; $display("FAIL single_len: got %0d words, want 11", n); end
    for (int i = 0; i < 11; i++) begin
      tests++;
      if (got[i] !== exp[i]) begin
        fails++; $display("FAIL single_w%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
    tests++;
    if (busy_err != 0) begin fails++; $display("FAIL single_busy: %0d cycles busy!=fifo_wr, want 0", busy_err); end
    tests++;
    if (evt_cnt !== 16'd1) begin fails++; $display("FAIL single_evt_cnt: got %0d want 1", evt_cnt); end
    tests++;
    if (fifo_din !== exp[10]) begin fails++; $display("FAIL single_hold: got %h want %h", fifo_din, exp[10]); end
  endtask

  task automatic test_cal();
    int n;
    logic [31:0] c;
    pulse(1'b1);
    capture(n);
    c = '0;
    for (int i = 0; i < 10; i++) c ^= got[i];
    tests++;
    if (got[0] !== 32'h4143414c) begin fails++; $display("FAIL cal_pid: got %h want 4143414c", got[0]); end
    tests++;
    if (got[1] !== 32'h00010001) begin fails++; $display("FAIL cal_w1: got %h want 00010001", got[1]); end
    tests++;
    if (got[10] !== c || n != 11) begin fails++; $display("FAIL cal_csum: got %h (n=%0d) want %h (n=11)", got[10], n, c); end
    tests++;
    if (evt_cnt !== 16'd1) begin fails++; $display("FAIL cal_evt_cnt: got %0d want 1", evt_cnt); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (fifo_wr) begin if (n < 32) got[n] = fifo_din; n++; end
      evt_rdy = (cyc == 0 || cyc == 5 || cyc == 12);
      @(negedge clk);
    end
    evt_rdy = 1'b0;
    tests++;
    if (n != 22) begin fails++; $display("FAIL b2b_words: got %0d want 22", n); end
    tests++;
    if (got[1] !== 32'h00010001) begin fails++; $display("FAIL b2b_first_cnt: got %h want 00010001", got[1]); end
    tests++;
    if (got[11] !== 32'h4142504d || got[12] !== 32'h00010002) begin
      fails++; $display("FAIL b2b_second: got %h %h want 4142504d 00010002", got[11], got[12]);
    end
    tests++;
    if (drop_cnt !== 16'd1 || evt_cnt !== 16'd2) begin
      fails++; $display("FAIL b2b_counts: drop=%0d evt=%0d want drop=1 evt=2", drop_cnt, evt_cnt);
    end
  endtask

  task automatic test_prog_full();
    int n, wr;
    do_reset();
    fifo_prog_full = 1'b1;
    pulse(1'b0);
    fifo_prog_full = 1'b0;
    wr = 0;
    for (int i = 0; i < 15; i++) begin wr += int'(fifo_wr); @(negedge clk); end
    tests++;
    if (wr != 0 || drop_cnt !== 16'd1) begin
      fails++; $display("FAIL pf_drop: wr cycles=%0d drop=%0d want 0 and 1", wr, drop_cnt);
    end
    pulse(1'b0);
    capture(n);
    tests++;
    if (n != 11 || got[1] !== 32'h00010001) begin
      fails++; $display("FAIL pf_resume: n=%0d w1=%h want 11 00010001", n, got[1]);
    end
  endtask

  task automatic test_rst_abort();
    int n;
    do_reset();
    pulse(1'b0);
    repeat (5) @(negedge clk);
    tests++;
    if (fifo_din !== 32'h22) begin fails++; $display("FAIL abort_w5: got %h want 00000022", fifo_din); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({fifo_wr, busy, fifo_din, evt_cnt, drop_cnt} !== '0) begin
      fails++; $display("FAIL abort_outputs: wr=%b busy=%b din=%h evt=%h drop=%h want all zero",
                        fifo_wr, busy, fifo_din, evt_cnt, drop_cnt);
    end
    @(negedge clk);
    pulse(1'b0);
    capture(n);
    tests++;
    if (n != 11 || got[1] !== 32'h00010001) begin
      fails++; $display("FAIL abort_next: n=%0d w1=%h want 11 00010001", n, got[1]);
    end
  endtask

  task automatic test_rst_evt_no();
    int n;
    rst_evt_no = 1'b1;
    pulse(1'b0);
    rst_evt_no = 1'b0;
    capture(n);
    tests++;
    if (got[1] !== 32'h00010000 || evt_cnt !== 16'd0) begin
      fails++; $display("FAIL clr_snapshot: w1=%h evt=%0d want 00010000 0", got[1], evt_cnt);
    end
  endtask

  task automatic test_nch8();
    logic [31:0] exp[17];
    int n;
    exp = '{32'h4142504d, 32'h00010001, 32'h01020304, 32'h05060011, 32'h1, 32'h2, 32'h3,
            32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h00010002, 32'h00030004, 32'h00050006,
            32'h00070008, 32'h0};
    for (int i = 0; i < 16; i++) exp[16] ^= exp[i];
    do_reset();
    evt8 = 1'b1;
    @(negedge clk);
    evt8 = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (fifo_wr8) begin if (n < 32) got[n] = fifo_din8; n++; end
      else if (n > 0) break;
      @(negedge clk);
    end
    tests++;
    if (n != 17) begin fails++; $display("FAIL n8_len: got %0d want 17", n); end
    for (int i = 0; i < 17; i++) begin
      tests++;
      if (got[i] !== exp[i]) begin fails++; $display("FAIL n8_w%0d: got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_cal();
    test_rst_evt_no();
    test_back_to_back();
    test_prog_full();
    test_rst_abort();
    test_nch8();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/event_packer.md
# event_packer

Parametrised slow-path event packetizer: snapshots per-event position, per-channel power and per-channel max results when an event completes and streams them as a fixed-length, checksummed packet of 32-bit words into the slow FIFO read by the motherboard. It is the successor to the hard-coded 16-word packing sequencer in the signal-processing top level. It generalises channel count and adds:

- a distinct calibration packet type,
- FIFO back-pressure with drop accounting,
- an XOR checksum trailer.

## Interface
Parameters:
- NCH, 4: number of ADC channels; must be even, 2..16.
- DATA_WIDTH, 16: width of position/max/status fields.
- SF_WIDTH, 32: width of power fields (fixed-point); must be 32.
- PID, 32'h4142504d: header word for real events ("ABPM").
- CAL_PID, 32'h4143414c: header word for calibration events ("ACAL").

Ports:
- clk  in  1  processing clock (10 MHz domain).
- rst  in  1  synchronous, active-high reset.
- evt_rdy  in  1  one-clk pulse: the result inputs below are valid this cycle.
- cal_flag  in  1  qualifies evt_rdy as a calibration event.
- rst_evt_no  in  1  level; clears evt_cnt and drop_cnt.
- status  in  DATA_WIDTH  status bits to embed.
- x, y, s  in  DATA_WIDTH each  position results.
- power  in  NCH*SF_WIDTH  channel powers; ch0 in the LSBs.
- max  in  NCH*DATA_WIDTH  channel max ADC values; ch0 in the LSBs.
- fifo_prog_full  in  1  slow FIFO programmable-full flag.
- fifo_wr  out  1  FIFO write enable.
- fifo_din  out  32  FIFO write data.
- busy  out  1  packet in progress.
- evt_cnt  out  16  real-event counter.
- drop_cnt  out  16  dropped-event counter; saturates at 16'hFFFF.

## Operation
- Packet length L = 5 + NCH + NCH/2 words (L = 11 at NCH=4). Word order:
  - w0: PID, or CAL_PID for a calibration event.
  - w1: {status, evt_cnt_snapshot}.
  - w2: {x, y}.
  - w3: {s, L[15:0]}.
  - w4 .. w(3+NCH): power[ch0] .. power[chNCH-1].
  - next NCH/2 words: {max[ch2k], max[ch2k+1]}, upper half first.
  - w(L-1): XOR of w0..w(L-2).
- FSM states: IDLE, SEND.
- IDLE -> SEND on evt_rdy && !fifo_prog_full:
  - all inputs are captured into a snapshot register;
  - the word index is cleared;
  - the checksum accumulator is cleared.
- Real accepted event: evt_cnt increments; the snapshot carries the incremented value (the first event after reset reads 1).
- Calibration accepted event: evt_cnt is unchanged; the snapshot carries the current value.
- SEND emits one word per cycle. SEND -> IDLE after word L-1.
- Drop, with drop_cnt += 1 (saturating):
  - evt_rdy while in SEND;
  - evt_rdy in IDLE with fifo_prog_full high.
- fifo_prog_full is sampled only at acceptance. Once a packet starts, it is never stalled or truncated; FIFO headroom ≥ L is the system's responsibility.
- rst_evt_no has priority over any increment:
  - evt_cnt and drop_cnt go to 0 the next cycle;
  - an event accepted in that same cycle snapshots 0.
- Simultaneous drop and rst_evt_no: drop_cnt = 0.
- evt_cnt wraps 16'hFFFF -> 0.

## Timing
- Reset values:
  - fifo_wr 0, fifo_din 0, busy 0, evt_cnt 0, drop_cnt 0;
  - state IDLE.
- Latency: evt_rdy sampled at edge T.
  - fifo_wr = 1 with w0 on fifo_din during cycle T+1.
  - word k is in cycle T+1+k.
  - fifo_wr drops at T+1+L.
- fifo_din is registered and valid only while fifo_wr = 1. It holds its last value otherwise.
- busy = 1 exactly while fifo_wr = 1 (L cycles).
- Minimum accepted event spacing is L+1 cycles. An evt_rdy coincident with the last word is dropped.
- rst during SEND:
  - aborts the packet; fifo_wr = 0 from the next cycle;
  - the partial packet remains, and the FIFO is reset by the same rst.
- Outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset, then a single real event, NCH=4, x=16'h0102, y=16'h0304, s=16'h0506, power=32'h11,22,33,44, max=16'hA,B,C,D, status=16'h0001:
  - 11 consecutive writes: 4142504d, 00010001, 01020304, 0506000B, 11, 22, 33, 44, 000A000B, 000C000D, then the XOR of the preceding ten;
  - evt_cnt=1, busy high for 11 cycles.
- Calibration event after one real event:
  - w0 = 4143414c, w1 low half = 0001;
  - evt_cnt stays 1.
- evt_rdy pulses at T and T+5 (inside the packet), then at T+12 (exactly L+1 later):
  - first and third are packed (evt_cnt 1, 2);
  - drop_cnt = 1.
- fifo_prog_full=1 at evt_rdy: no fifo_wr, drop_cnt = 1.
  - Release prog_full, then evt_rdy: a packet is sent with evt_cnt = 1.
- rst asserted at word 5 of a packet:
  - fifo_wr low on the next cycle;
  - all outputs at reset values;
  - the next event yields a full packet with evt_cnt = 1.
- NCH=8 build: L = 17; w3 low half = 0011; 4 max words; checksum verified.
